// File: rtl/cla_seq_ctrl_pkg.sv
// Shared types and defaults for the in-array carry-lookahead add sequencer.
// Holds the FSM encoding and the operand sizing defaults.
package cla_seq_ctrl_pkg;

  localparam int NIB_MAX_DEF = 8;
  localparam int IDX_W_DEF   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    ADD  = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/cla_seq_ctrl_nib.sv
// Combinational 4-bit carry slice fed by bit-line sensing.
// bl is generate (A&B); NOR(bl,blb) recovers propagate (A^B).
module cla_nib (
  input  logic [3:0] bl,
  input  logic [3:0] blb,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] prop;

  assign prop = ~(bl | blb);

  // Ripple the carry LSB to MSB through the nibble.
  always_comb begin : ripple
    logic c;
    sum = '0;
    c   = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i] = prop[i] ^ c;
      c      = bl[i] | (prop[i] & c);
    end
    cout = c;
  end

endmodule

// File: rtl/cla_seq_ctrl.sv
// Nibble-serial add sequencer: reads operand rows, adds, writes result.
// One nibble per READ/ADD pair; FIN reports the final carry.
module cla_seq_ctrl
  import cla_seq_ctrl_pkg::*;
#(
  parameter int NIB_MAX = NIB_MAX_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W:0]   op_len,
  input  logic             cin_init,
  input  logic             abort,
  input  logic [3:0]       bl,
  input  logic [3:0]       blb,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_idx,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output logic [3:0]       wr_data,
  output logic             busy,
  output logic             done,
  output logic             cout
);

  localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(NIB_MAX);
  localparam logic [IDX_W:0] ONE     = (IDX_W+1)'(1);

  state_t         state;
  state_t         state_nx;
  logic [IDX_W:0] idx;
  logic [IDX_W:0] len;
  logic [IDX_W:0] len_in;
  logic           carry;
  logic           cout_q;
  logic           accept;
  logic           last;
  logic [3:0]     nib_sum;
  logic           nib_cout;

  // idx carries one extra bit so the final increment never wraps.
  assign len_in = (op_len > LEN_MAX) ? LEN_MAX : op_len;
  assign accept = start && (state == IDLE);
  assign last   = ((idx + ONE) == len);
  assign busy   = (state != IDLE);

  cla_nib u_nib (
    .bl   (bl),
    .blb  (blb),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and array strobes; abort gates the write.
  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    rd_idx   = '0;
    wr_en    = 1'b0;
    wr_idx   = '0;
    wr_data  = '0;
    done     = 1'b0;
    cout     = cout_q;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (len_in == '0) ? FIN : READ;
      end
      READ: begin
        rd_en    = 1'b1;
        rd_idx   = idx[IDX_W-1:0];
        state_nx = abort ? IDLE : ADD;
      end
      ADD: begin
        if (abort) begin
          state_nx = IDLE;
        end else begin
          wr_en    = 1'b1;
          wr_idx   = idx[IDX_W-1:0];
          wr_data  = nib_sum;
          state_nx = last ? FIN : READ;
        end
      end
      FIN: begin
        done     = 1'b1;
        cout     = carry;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operation context: index, length, running carry, held carry-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      len    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      if (accept) begin
        idx   <= '0;
        len   <= len_in;
        carry <= cin_init;
      end else if ((state == ADD) && !abort) begin
        idx   <= idx + ONE;
        carry <= nib_cout;
      end
      if (state == FIN)
        cout_q <= carry;
    end
  end

endmodule
